sr_driver: RTL
==============

SR_DRIVER -- requirements
Module: sr_driver

Interface
REQ-001 Parameter PULSE_W, default 3: cycles s or r is held high per write, legal range 1..255.
REQ-002 Parameter GAP_W, default 1: cycles s and r are both low after a pulse, before ack; legal range 0..255.
REQ-003 Parameter INIT_W, default 4: cycles the init force is held after reset release, legal range 1..255.
REQ-004 Parameter INIT_VAL, default 0: initial latch state, where 0 drives preclear_ low and 1 drives preset_ low.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  1  single-cycle write strobe, sampled only in IDLE.
REQ-008 val  input  1  value to write into the latch, sampled with req.
REQ-009 latch_q  input  1  q feedback from the driven SR latch.
REQ-010 s  output  1  set drive to the latch.
REQ-011 r  output  1  reset drive to the latch.
REQ-012 preset_  output  1  active-low preset to the latch.
REQ-013 preclear_  output  1  active-low preclear to the latch.
REQ-014 ack  output  1  one-cycle write-complete pulse.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 state_q  output  1  shadow copy of the value last written to the latch.
REQ-017 err  output  1  sticky feedback-mismatch flag.

Function
REQ-018 FSM states SHALL be INIT, IDLE, PULSE, GAP and DONE; every output SHALL be driven directly from flops.
REQ-019 INIT behaviour:
- preset_/preclear_ per INIT_VAL held low for INIT_W cycles after reset release;
- then both outputs go 1, state_q=INIT_VAL, and the FSM enters IDLE.
REQ-020 IDLE with req=1 and val!=state_q SHALL enter PULSE.
- s=val, r=~val, starting the cycle after req;
- held for exactly PULSE_W cycles.
REQ-021 IDLE with req=1 and val==state_q SHALL skip the pulse: DONE next cycle, s=r=0 throughout.
REQ-022 After PULSE the FSM SHALL spend GAP_W cycles in GAP with s=r=0; when GAP_W=0 it SHALL go straight to DONE.
REQ-023 On entering DONE, state_q SHALL update to val.
REQ-024 DONE SHALL last one cycle with ack=1, then the FSM SHALL return to IDLE.
REQ-025 Latency, for req at cycle n:
- pulse write: ack at n+1+PULSE_W+GAP_W;
- skipped write: ack at n+1.
REQ-026 req outside IDLE SHALL be ignored, with no queuing.
REQ-027 Output invariants, in every cycle:
- s and r are never both 1;
- preset_ and preclear_ are never both 0;
- neither s nor r is 1 while preset_ or preclear_ is 0.

Reset
REQ-028 Reset assertion SHALL act immediately, with no clock required, and set:
- FSM to INIT;
- s=r=ack=0, busy=1, err=0, state_q=INIT_VAL;
- preset_/preclear_ forced per INIT_VAL.
REQ-029 Reset asserted mid-PULSE or mid-GAP SHALL abort the write (no ack); INIT restarts with a full INIT_W count after reset release.

Configuration
REQ-030 Macro SR_DRIVER_CHECK_EN, when defined:
- latch_q is sampled in DONE and at INIT exit;
- any mismatch with state_q (INIT_VAL at INIT exit) sets err=1, cleared only by reset.
REQ-031 When SR_DRIVER_CHECK_EN is undefined, err SHALL be constant 0 and latch_q SHALL be ignored.

Verification
REQ-032 reset pulse, INIT_VAL=0, INIT_W=4 -> preclear_=0 immediately; preclear_=1 and busy=0 on the 4th clock after release; state_q=0.
REQ-033 IDLE, state_q=0, req=1 val=1 at cycle 10, PULSE_W=3 GAP_W=1 -> s=1 cycles 11-13, s=r=0 cycle 14, ack=1 cycle 15, state_q=1.
REQ-034 IDLE, state_q=1, req=1 val=1 -> ack at next cycle, s=r=0 throughout.
REQ-035 req pulses during PULSE and GAP -> ignored; exactly one ack; a second req after returning to IDLE is accepted.
REQ-036 reset during cycle 2 of PULSE -> s=0 and preclear_=0 without a clock, no ack, INIT replayed.
REQ-037 With SR_DRIVER_CHECK_EN defined, latch_q held at 0 while writing val=1 -> err=1 from the cycle after DONE and held until reset; with the macro undefined -> err stays 0.

Source files
------------

// File: rtl/sr_driver.sv
// -----------------------------------------------------------------------------
// sr_driver
//
// Write sequencer for an external SR latch. After reset it holds the latch's
// preset_/preclear_ pin low for INIT_W cycles to force the INIT_VAL state,
// then accepts single-cycle write strobes. A write whose value differs from
// the shadow copy drives s (or r) for PULSE_W cycles, idles both drives for
// GAP_W cycles, and then pulses ack. A write of the value already held skips
// the pulse and acks on the next cycle.
//
// Optional feature macro: SR_DRIVER_CHECK_EN
//   When defined, latch_q is compared against the expected latch value in
//   DONE and at INIT exit, and any disagreement sets the sticky err flag.
//   When undefined, err is tied low and latch_q is unused.
//
// Handshake: req/val are a fire-and-forget strobe. The strobe is accepted
// only in a cycle where busy is low; a strobe seen while busy is high is
// dropped, not queued. Each accepted strobe produces exactly one ack pulse,
// unless reset aborts the write first.
//
// Every output, including the fsm_state debug view, comes straight from a
// flop. The next-state logic computes the next value of each output alongside
// the next state, and a single register stage captures them together.
// -----------------------------------------------------------------------------
module sr_driver #(
   parameter int PULSE_W  = 3,
   parameter int GAP_W    = 1,
   parameter int INIT_W   = 4,
   parameter bit INIT_VAL = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req,
   input  logic       val,
   input  logic       latch_q,
   output logic       s,
   output logic       r,
   output logic       preset_,
   output logic       preclear_,
   output logic       ack,
   output logic       busy,
   output logic       state_q,
   output logic       err,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_PULSE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Terminal counts for the shared 8-bit phase counter. The counter starts
   // at 0 on entry to a timed state, so the last cycle is count W-1.
   localparam logic [7:0] INIT_LAST  = 8'(INIT_W - 1);
   localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
   localparam logic [7:0] GAP_LAST   = (GAP_W > 0) ? 8'(GAP_W - 1) : 8'd0;
   localparam bit         HAS_GAP    = (GAP_W > 0);

   // Registered state
   state_t     state_r;
   logic [7:0] cnt_r;
   logic       wval_r;     // value being written, captured with req

   // Next-state values
   state_t     state_d;
   logic [7:0] cnt_d;
   logic       wval_d;
   logic       s_d;
   logic       r_d;
   logic       ack_d;
   logic       busy_d;
   logic       preset_d;
   logic       preclear_d;
   logic       state_q_d;

   // Next-state logic: sequencing of INIT, IDLE, PULSE, GAP and DONE
   always_comb begin
      state_d = state_r;
      cnt_d   = cnt_r;
      wval_d  = wval_r;

      case (state_r)
         ST_INIT: begin
            if (cnt_r == INIT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_r + 8'd1;
            end
         end

         ST_IDLE: begin
            if (req) begin
               wval_d = val;
               cnt_d  = 8'd0;
               // Writing the value already held needs no pulse on the latch.
               if (val != state_q) begin
                  state_d = ST_PULSE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_PULSE: begin
            if (cnt_r == PULSE_LAST) begin
               cnt_d   = 8'd0;
               state_d = HAS_GAP ? ST_GAP : ST_DONE;
            end else begin
               cnt_d = cnt_r + 8'd1;
            end
         end

         ST_GAP: begin
            if (cnt_r == GAP_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_r + 8'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_INIT;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Output decode from the next state, so each output flop holds the value
   // belonging to the state the FSM occupies in the same cycle. s/r are only
   // ever driven in PULSE and preset_/preclear_ only ever low in INIT, which
   // keeps the drive and force pins mutually exclusive by construction.
   always_comb begin
      s_d        = (state_d == ST_PULSE) &&  wval_d;
      r_d        = (state_d == ST_PULSE) && !wval_d;
      ack_d      = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE);
      preset_d   = !((state_d == ST_INIT) &&  INIT_VAL);
      preclear_d = !((state_d == ST_INIT) && !INIT_VAL);
      state_q_d  = state_q;
      if (state_d == ST_DONE) begin
         state_q_d = wval_d;
      end
      if ((state_r == ST_INIT) && (state_d == ST_IDLE)) begin
         state_q_d = INIT_VAL;
      end
   end

   // State, counter and output registers; reset forces the INIT values at once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= ST_INIT;
         cnt_r     <= 8'd0;
         wval_r    <= INIT_VAL;
         s         <= 1'b0;
         r         <= 1'b0;
         ack       <= 1'b0;
         busy      <= 1'b1;
         preset_   <= !INIT_VAL;
         preclear_ <= INIT_VAL;
         state_q   <= INIT_VAL;
      end else begin
         state_r   <= state_d;
         cnt_r     <= cnt_d;
         wval_r    <= wval_d;
         s         <= s_d;
         r         <= r_d;
         ack       <= ack_d;
         busy      <= busy_d;
         preset_   <= preset_d;
         preclear_ <= preclear_d;
         state_q   <= state_q_d;
      end
   end

   assign fsm_state = state_r;

`ifdef SR_DRIVER_CHECK_EN
   logic err_d;

   // Feedback check: latch must agree with the shadow value after a write
   // and with INIT_VAL once the init force is released
   always_comb begin
      err_d = err;
      if ((state_r == ST_DONE) && (latch_q != state_q)) begin
         err_d = 1'b1;
      end
      if ((state_r == ST_INIT) && (state_d == ST_IDLE) && (latch_q != INIT_VAL)) begin
         err_d = 1'b1;
      end
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else begin
         err <= err_d;
      end
   end
`else
   logic unused_latch_q;
   assign unused_latch_q = latch_q;
   assign err            = 1'b0;
`endif

endmodule
